// File: rtl/cpu_decode_stage_pkg.sv
// Shared CPU control types: opcodes, select encodings and the decoded control bundle.
package pkg_cpu_types;

  localparam int CPU_XLEN = 32;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_fun_t;

  typedef enum logic [1:0] {BR_BEQ, BR_BNE, BR_BLT, BR_BGE} br_fun_t;
  typedef enum logic      {OP1_RD1, OP1_PC} op1_sel_t;
  typedef enum logic [1:0] {OP2_RD2, OP2_I_IM, OP2_S_IM, OP2_U_IM} op2_sel_t;
  typedef enum logic [1:0] {WB_ALU_OUT, WB_MEM_Q, WB_NXT_PC, WB_U_IM} wb_sel_t;
  typedef enum logic [1:0] {PC_NXT_PC, PC_PLUS_JIM, PC_ALU_OUT, PC_BCOMP} pc_sel_t;

  typedef struct packed {
    logic [CPU_XLEN-1:0] pc;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    alu_fun_t            alu_fun;
    br_fun_t             br_fun;
    op1_sel_t            op1_sel;
    op2_sel_t            op2_sel;
    wb_sel_t             wb_sel;
    pc_sel_t             pc_sel;
    logic                rf_we;
    logic                mem_we;
    logic                mem_re;
    logic                illegal;
    logic [CPU_XLEN-1:0] i_im;
    logic [CPU_XLEN-1:0] s_im;
    logic [CPU_XLEN-1:0] u_im;
    logic [CPU_XLEN-1:0] b_im;
    logic [CPU_XLEN-1:0] j_im;
  } ctrl_t;

endpackage

// File: rtl/cpu_decode_stage_if.sv
// Fetch-to-execute bus of the decode stage: fetch handshake, flush and decoded bundle.
interface cpu_decode_stage_if;
  import pkg_cpu_types::*;

  logic                if_valid;
  logic                if_ready;
  logic [CPU_XLEN-1:0] if_pc;
  logic [31:0]         if_instr;
  logic                flush;
  logic                id_valid;
  logic                id_ready;
  ctrl_t               id_ctrl;

  modport slave (
    input  if_valid, if_pc, if_instr, flush, id_ready,
    output if_ready, id_valid, id_ctrl
  );

  modport master (
    output if_valid, if_pc, if_instr, flush, id_ready,
    input  if_ready, id_valid, id_ctrl
  );
endinterface

// File: rtl/cpu_decode_stage_comb.sv
// Purely combinational RV32I-subset decoder: instruction word and PC to control bundle.
module cpu_decode_comb
  import pkg_cpu_types::*;
(
  input  logic [31:0]         instr,
  input  logic [CPU_XLEN-1:0] pc,
  output ctrl_t               ctrl
);

  opcode_t    opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       bad;

  assign opc = opcode_t'(instr[6:0]);
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  always_comb begin
    ctrl      = '0;
    bad       = 1'b0;
    ctrl.pc   = pc;
    ctrl.rs1  = instr[19:15];
    ctrl.rs2  = instr[24:20];
    ctrl.rd   = instr[11:7];
    ctrl.i_im = {{20{instr[31]}}, instr[31:20]};
    ctrl.s_im = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    ctrl.u_im = {instr[31:12], 12'b0};
    ctrl.b_im = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    ctrl.j_im = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    case (opc)
      OPC_LUI: begin
        ctrl.wb_sel = WB_U_IM;
        ctrl.rf_we  = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl.op1_sel = OP1_PC;
        ctrl.op2_sel = OP2_U_IM;
        ctrl.rf_we   = 1'b1;
      end
      OPC_JAL: begin
        ctrl.pc_sel = PC_PLUS_JIM;
        ctrl.wb_sel = WB_NXT_PC;
        ctrl.rf_we  = 1'b1;
      end
      OPC_JALR: begin
        bad          = (f3 != 3'b000);
        ctrl.op2_sel = OP2_I_IM;
        ctrl.pc_sel  = PC_ALU_OUT;
        ctrl.wb_sel  = WB_NXT_PC;
        ctrl.rf_we   = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.pc_sel = PC_BCOMP;
        case (f3)
          3'b000:  ctrl.br_fun = BR_BEQ;
          3'b001:  ctrl.br_fun = BR_BNE;
          3'b100:  ctrl.br_fun = BR_BLT;
          3'b101:  ctrl.br_fun = BR_BGE;
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        bad          = (f3 != 3'b010);
        ctrl.op2_sel = OP2_I_IM;
        ctrl.mem_re  = 1'b1;
        ctrl.wb_sel  = WB_MEM_Q;
        ctrl.rf_we   = 1'b1;
      end
      OPC_STORE: begin
        bad          = (f3 != 3'b010);
        ctrl.op2_sel = OP2_S_IM;
        ctrl.mem_we  = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl.op2_sel = OP2_I_IM;
        ctrl.rf_we   = 1'b1;
        case (f3)
          3'b000: ctrl.alu_fun = ALU_ADD;
          3'b001: ctrl.alu_fun = ALU_SLL;
          3'b010: ctrl.alu_fun = ALU_SLT;
          3'b011: ctrl.alu_fun = ALU_SLTU;
          3'b100: ctrl.alu_fun = ALU_XOR;
          3'b101: ctrl.alu_fun = instr[30] ? ALU_SRA : ALU_SRL;
          3'b110: ctrl.alu_fun = ALU_OR;
          default: ctrl.alu_fun = ALU_AND;
        endcase
        // only the shift forms carry funct7 in the immediate field
        if ((f3 == 3'b001 || f3 == 3'b101) && f7 != 7'h00 && f7 != 7'h20)
          bad = 1'b1;
      end
      OPC_OP: begin
        ctrl.op2_sel = OP2_RD2;
        ctrl.rf_we   = 1'b1;
        if (f7 != 7'h00 && f7 != 7'h20) bad = 1'b1;
        case ({f7[5], f3})
          4'b0000: ctrl.alu_fun = ALU_ADD;
          4'b1000: ctrl.alu_fun = ALU_SUB;
          4'b0001: ctrl.alu_fun = ALU_SLL;
          4'b0010: ctrl.alu_fun = ALU_SLT;
          4'b0011: ctrl.alu_fun = ALU_SLTU;
          4'b0100: ctrl.alu_fun = ALU_XOR;
          4'b0101: ctrl.alu_fun = ALU_SRL;
          4'b1101: ctrl.alu_fun = ALU_SRA;
          4'b0110: ctrl.alu_fun = ALU_OR;
          4'b0111: ctrl.alu_fun = ALU_AND;
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase

    if (ctrl.rd == 5'd0) ctrl.rf_we = 1'b0;

    if (bad) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/cpu_decode_stage.sv
// Registered decode stage: 2-entry skid buffer around cpu_decode_comb with flush.
module cpu_decode_stage
  import pkg_cpu_types::*;
#(
  parameter int XLEN = 32
) (
  input logic               clk,
  input logic               rst_n,
  cpu_decode_stage_if.slave bus
);

  logic [XLEN-1:0] pc_in;
  ctrl_t           dec;
  ctrl_t           out_ctrl;
  ctrl_t           skid_ctrl;
  logic            out_v;
  logic            skid_v;
  logic            in_xfer;
  logic            out_xfer;

  assign pc_in = bus.if_pc;

  cpu_decode_comb u_dec (
    .instr (bus.if_instr),
    .pc    (pc_in),
    .ctrl  (dec)
  );

  // if_ready comes straight from a flop, never from id_ready or flush
  assign in_xfer  = bus.if_valid & ~skid_v;
  assign out_xfer = out_v & bus.id_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v     <= 1'b0;
      skid_v    <= 1'b0;
      out_ctrl  <= '0;
      skid_ctrl <= '0;
    end else if (bus.flush) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (!out_v || out_xfer) begin
      if (skid_v) begin
        out_ctrl <= skid_ctrl;
        out_v    <= 1'b1;
        skid_v   <= 1'b0;
      end else if (in_xfer) begin
        out_ctrl <= dec;
        out_v    <= 1'b1;
      end else begin
        out_v <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_ctrl <= dec;
      skid_v    <= 1'b1;
    end
  end

  assign bus.if_ready = ~skid_v;
  assign bus.id_valid = out_v;
  assign bus.id_ctrl  = out_ctrl;

endmodule

// File: tb/tb_cpu_decode_stage.sv
// Bench for cpu_decode_stage: directed scenarios plus random traffic against a queue model.
module tb_cpu_decode_stage;
  import pkg_cpu_types::*;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  cpu_decode_stage_if bus ();

  cpu_decode_stage #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  ctrl_t q[$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decoder built from the ISA tables, independent of the RTL structure.
  function automatic ctrl_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    ctrl_t      c;
    bit         ok;
    bit         writes;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    alu_fun_t   base [8];
    base = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    c = '0; ok = 1; writes = 0;
    c.pc = pc; c.rs1 = w[19:15]; c.rs2 = w[24:20]; c.rd = w[11:7];
    c.i_im = 32'($signed(w[31:20]));
    c.s_im = 32'($signed({w[31:25], w[11:7]}));
    c.u_im = w & 32'hFFFF_F000;
    c.b_im = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
    c.j_im = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
    if (op == 7'b0110111) begin
      c.wb_sel = WB_U_IM; writes = 1;
    end else if (op == 7'b0010111) begin
      c.op1_sel = OP1_PC; c.op2_sel = OP2_U_IM; writes = 1;
    end else if (op == 7'b1101111) begin
      c.pc_sel = PC_PLUS_JIM; c.wb_sel = WB_NXT_PC; writes = 1;
    end else if (op == 7'b1100111) begin
      ok = (f3 == 0);
      c.op2_sel = OP2_I_IM; c.pc_sel = PC_ALU_OUT; c.wb_sel = WB_NXT_PC; writes = 1;
    end else if (op == 7'b1100011) begin
      c.pc_sel = PC_BCOMP;
      if      (f3 == 0) c.br_fun = BR_BEQ;
      else if (f3 == 1) c.br_fun = BR_BNE;
      else if (f3 == 4) c.br_fun = BR_BLT;
      else if (f3 == 5) c.br_fun = BR_BGE;
      else ok = 0;
    end else if (op == 7'b0000011) begin
      ok = (f3 == 2);
      c.op2_sel = OP2_I_IM; c.mem_re = 1; c.wb_sel = WB_MEM_Q; writes = 1;
    end else if (op == 7'b0100011) begin
      ok = (f3 == 2);
      c.op2_sel = OP2_S_IM; c.mem_we = 1;
    end else if (op == 7'b0010011) begin
      c.op2_sel = OP2_I_IM; writes = 1;
      c.alu_fun = base[f3];
      if (f3 == 5 && w[30]) c.alu_fun = ALU_SRA;
      if ((f3 == 1 || f3 == 5) && !(f7 == 0 || f7 == 7'h20)) ok = 0;
    end else if (op == 7'b0110011) begin
      writes = 1;
      if (f7 == 0) c.alu_fun = base[f3];
      else if (f7 == 7'h20 && f3 == 0) c.alu_fun = ALU_SUB;
      else if (f7 == 7'h20 && f3 == 5) c.alu_fun = ALU_SRA;
      else ok = 0;
    end else begin
      ok = 0;
    end
    c.rf_we = writes && (c.rd != 0);
    if (!ok) begin
      c = '0;
      c.illegal = 1;
    end
    return c;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [9];
    logic [31:0] w;
    int          k;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    w = $urandom;
    k = $urandom_range(0, 10);
    if (k < 9) w[6:0] = ops[k];
    case ($urandom_range(0, 3))
      0, 1: w[31:25] = 7'h00;
      2:    w[31:25] = 7'h20;
      default: ;
    endcase
    if ($urandom_range(0, 15) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  // Check outputs against the queue, drive one cycle of inputs, advance the model.
  task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] instr,
                      input bit rdy, input bit fl);
    bit in_x;
    bit out_x;
    chk("id_valid", 256'(bus.id_valid), 256'(q.size() > 0));
    chk("if_ready", 256'(bus.if_ready), 256'(q.size() < 2));
    if (q.size() > 0) chk("id_ctrl", 256'(bus.id_ctrl), 256'(q[0]));
    bus.if_valid = v; bus.if_pc = pc; bus.if_instr = instr;
    bus.id_ready = rdy; bus.flush = fl;
    in_x  = v && (q.size() < 2);
    out_x = rdy && (q.size() > 0);
    if (fl) begin
      q.delete();
    end else begin
      if (out_x) void'(q.pop_front());
      if (in_x) q.push_back(ref_decode(instr, pc));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 32'h0, 32'h0, rdy, 1'b0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    bus.if_valid = 0; bus.if_pc = '0; bus.if_instr = '0;
    bus.id_ready = 0; bus.flush = 0;
    #12;
    chk("rst_id_valid", 256'(bus.id_valid), 256'(0));
    chk("rst_if_ready", 256'(bus.if_ready), 256'(1));
    chk("rst_id_ctrl", 256'(bus.id_ctrl), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ADDI x5,x0,-1
    step(1, 32'h0, 32'hFFF0_0293, 1, 0);
    chk("addi_valid", 256'(bus.id_valid), 256'(1));
    chk("addi_alu", 256'(bus.id_ctrl.alu_fun), 256'(ALU_ADD));
    chk("addi_op2", 256'(bus.id_ctrl.op2_sel), 256'(OP2_I_IM));
    chk("addi_iim", 256'(bus.id_ctrl.i_im), 256'(32'hFFFF_FFFF));
    chk("addi_rd", 256'(bus.id_ctrl.rd), 256'(5));
    chk("addi_we", 256'(bus.id_ctrl.rf_we), 256'(1));
    idle(1);

    // SW, BLT, JAL back to back
    step(1, 32'h100, 32'h0020_A423, 1, 0);
    chk("sw_mem_we", 256'(bus.id_ctrl.mem_we), 256'(1));
    chk("sw_rf_we", 256'(bus.id_ctrl.rf_we), 256'(0));
    step(1, 32'h104, 32'h0020_C863, 1, 0);
    chk("blt_br", 256'(bus.id_ctrl.br_fun), 256'(BR_BLT));
    chk("blt_pc", 256'(bus.id_ctrl.pc_sel), 256'(PC_BCOMP));
    chk("blt_bim", 256'(bus.id_ctrl.b_im), 256'(32'h10));
    step(1, 32'h108, 32'h0010_00EF, 1, 0);
    chk("jal_pc", 256'(bus.id_ctrl.pc_sel), 256'(PC_PLUS_JIM));
    chk("jal_wb", 256'(bus.id_ctrl.wb_sel), 256'(WB_NXT_PC));
    chk("jal_jim", 256'(bus.id_ctrl.j_im), 256'(32'h800));
    chk("jal_pcval", 256'(bus.id_ctrl.pc), 256'(32'h108));
    idle(1);

    // backpressure: three offered, two absorbed
    step(1, 32'h200, 32'h0010_0093, 0, 0);
    step(1, 32'h204, 32'h0020_0113, 0, 0);
    chk("bp_if_ready", 256'(bus.if_ready), 256'(0));
    step(1, 32'h208, 32'h0030_0193, 0, 0);
    chk("bp_pc_head", 256'(bus.id_ctrl.pc), 256'(32'h200));
    idle(1);
    chk("bp_pc_2nd", 256'(bus.id_ctrl.pc), 256'(32'h204));
    idle(1);
    chk("bp_ready_back", 256'(bus.if_ready), 256'(1));
    idle(1);

    // flush with both entries full and a new instruction presented
    step(1, 32'h300, 32'h0010_0093, 0, 0);
    step(1, 32'h304, 32'h0020_0113, 0, 0);
    step(1, 32'h308, 32'h0030_0193, 0, 1);
    chk("fl_id_valid", 256'(bus.id_valid), 256'(0));
    chk("fl_if_ready", 256'(bus.if_ready), 256'(1));
    idle(1);
    idle(1);

    // illegal forms and ADD x0
    step(1, 32'h400, 32'h0062_E463, 1, 0);
    chk("bltu_illegal", 256'(bus.id_ctrl.illegal), 256'(1));
    chk("bltu_en", 256'({bus.id_ctrl.rf_we, bus.id_ctrl.mem_we, bus.id_ctrl.mem_re}), 256'(0));
    step(1, 32'h404, 32'h0000_0000, 1, 0);
    chk("zero_illegal", 256'(bus.id_ctrl.illegal), 256'(1));
    chk("zero_valid", 256'(bus.id_valid), 256'(1));
    step(1, 32'h408, 32'h0020_8033, 1, 0);
    chk("addx0_illegal", 256'(bus.id_ctrl.illegal), 256'(0));
    chk("addx0_we", 256'(bus.id_ctrl.rf_we), 256'(0));
    idle(1);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 3) != 0), $urandom, rand_instr(),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0));
    end
    idle(1);
    idle(1);

    // async reset while stalled with two entries held
    step(1, 32'h500, 32'h0010_0093, 0, 0);
    step(1, 32'h504, 32'h0020_0113, 0, 0);
    bus.if_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_id_valid", 256'(bus.id_valid), 256'(0));
    chk("arst_id_ctrl", 256'(bus.id_ctrl), 256'(0));
    chk("arst_if_ready", 256'(bus.if_ready), 256'(1));
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step(1, 32'h600, 32'h0050_0293, 1, 0);
    idle(1);
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_decode_stage.md
# cpu_decode_stage

Registered instruction-decode stage of the TinyNPU control CPU (RV32I subset). Sits between instruction fetch and execute: accepts `{pc, instr}` from fetch over a valid/ready handshake and decodes them into the control bundle defined in `pkg_cpu_types`. The bundle is ALU function, branch function, operand selects, write-back select, PC select, enables and immediates. A 2-entry skid buffer fully decouples the two sides, so `if_ready` never depends combinationally on `id_ready`.

## Interface
Parameters:
- `XLEN`, 32: datapath and instruction width; only 32 is supported.

Ports:
- `clk`  in  1  system clock; all state is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_valid`  in  1  fetch presents an instruction.
- `if_ready`  out  1  stage can accept an instruction this cycle.
- `if_pc`  in  XLEN  PC of the presented instruction.
- `if_instr`  in  32  raw instruction word.
- `flush`  in  1  discard everything held and presented this cycle (taken branch or jump).
- `id_valid`  out  1  decoded bundle valid.
- `id_ready`  in  1  execute accepts the bundle.
- `id_ctrl`  out  `ctrl_t`  decoded bundle; field list is under Structure.

## Operation
- Transfer: a transfer occurs on a rising edge where valid and ready are both high, on either side.
- Decode is combinational on `if_instr`; results are captured into the output or skid register on accept.

Decode map (opcode → fields):
- LUI: `wb=WB_U_IM`, `rf_we=1`.
- AUIPC: `op1=OP1_PC`, `op2=OP2_U_IM`, `ALU_ADD`, `wb=WB_ALU_OUT`.
- JAL: `pc=PC_PLUS_JIM`, `wb=WB_NXT_PC`.
- JALR: `funct3` must be 000; `op2=OP2_I_IM`, `ALU_ADD`, `pc=PC_ALU_OUT`, `wb=WB_NXT_PC`.
- BRANCH: `funct3` 000/001/100/101 map to BEQ/BNE/BLT/BGE; `pc=PC_BCOMP`, `rf_we=0`. BLTU, BGEU and other `funct3` values are illegal.
- LOAD: LW only (`funct3`=010); `op2=OP2_I_IM`, `ALU_ADD`, `mem_re=1`, `wb=WB_MEM_Q`.
- STORE: SW only; `op2=OP2_S_IM`, `ALU_ADD`, `mem_we=1`, `rf_we=0`.
- OP-IMM: `op2=OP2_I_IM`; ALU function from `funct3`, plus `instr[30]` for SRAI. SLLI/SRLI/SRAI with `funct7` other than 0000000/0100000 are illegal.
- OP: `op2=OP2_RD2`; ALU function from `{funct7[5], funct3}`. Any other `funct7` value is illegal.

Decode rules:
- Default select for `op1` and `pc_sel` is `OP1_RD1` / `PC_NXT_PC`.
- `rf_we` is forced to 0 when `rd==0`.
- Illegal instruction or unknown opcode → `illegal=1`, `rf_we=mem_we=mem_re=0`, `pc_sel=PC_NXT_PC`, all other fields zero. The bundle still issues with `id_valid=1`.
- Immediates are sign-extended to XLEN. `u_im = {instr[31:12], 12'b0}`. B and J immediates have LSB 0.

Skid buffer:
- Two registers: `out` (drives `id_*`) and `skid`.
- `if_ready = !skid_v`, registered.
- Accept while `out` is empty or draining: the new instruction goes to `out`.
- Accept while `out` is stalled: the new instruction goes to `skid`.
- On an output transfer, `skid` moves into `out`, and `skid_v` clears unless a new input is captured into `skid` the same edge.

Flush:
- `out_v` and `skid_v` are cleared on the next edge, and any input presented that cycle is dropped.
- `flush` has priority over every other event.
- An output transfer coincident with `flush` still counts as completed.

## Timing
- Latency: instruction accepted at edge N → `id_valid` high after edge N, bundle stable until it transfers.
- Throughput: 1 instruction/cycle when `id_ready=1`.
- Backpressure: the stage absorbs one extra instruction after `id_ready` falls. `if_ready` drops on the next edge.
- Reset (async assert, sync release handled externally):
  - `out_v=0`, `skid_v=0`, so `id_valid=0` and `if_ready=1`.
  - `id_ctrl` is all zero: `ALU_ADD`, `BR_BEQ`, `OP1_RD1`, `OP2_RD2`, `WB_ALU_OUT`, `PC_NXT_PC`, enables 0.
- Reset mid-stall discards both entries.
- `id_ctrl` holds its value while `id_valid=0`; execute ignores it.
- No combinational path from `id_ready` or `flush` to `if_ready`.

## Structure
Additions to `pkg_cpu_types`:
- `opcode_t` enum covering the 9 supported opcodes.
- `ctrl_t` packed struct with fields: `pc`, `rs1`, `rs2`, `rd`, `alu_fun`, `br_fun`, `op1_sel`, `op2_sel`, `wb_sel`, `pc_sel`, `rf_we`, `mem_we`, `mem_re`, `illegal`, `i_im`, `s_im`, `u_im`, `b_im`, `j_im`.

Sub-module:
- `cpu_decode_comb`: purely combinational `instr, pc → ctrl_t`, reusable by the bench's reference model.
- `cpu_decode_stage` itself holds only the skid buffer and flush logic.

## Test plan
- `ADDI x5,x0,-1` (0xFFF00293), `id_ready=1` → one cycle later: `ALU_ADD`, `OP2_I_IM`, `i_im=0xFFFFFFFF`, `rd=5`, `rf_we=1`, `id_valid=1`.
- Back-to-back SW, BLT, JAL at PC 0x100/0x104/0x108 → three consecutive bundles:
  - SW: `mem_we=1`, `rf_we=0`.
  - BLT: `BR_BLT`, `PC_BCOMP`.
  - JAL: `PC_PLUS_JIM`, `WB_NXT_PC`, with the correct `j_im`.
- Hold `id_ready=0` while feeding 3 instructions → 2 accepted, `if_ready=0` after the second. Raise `id_ready` → bundles drain in order, `if_ready` returns to 1.
- `flush` asserted with both entries full plus `if_valid=1` → next cycle `id_valid=0`, `if_ready=1`, and no dropped instruction ever appears.
- BLTU (0x0062E463), word 0x00000000, and `ADD x0,x1,x2` → first two give `illegal=1` with enables 0; the third gives `illegal=0`, `rf_we=0`.
- Assert `rst_n=0` asynchronously while stalled with two entries held → `id_valid` falls immediately, `id_ctrl` is zero, `if_ready=1`.
